csoc_scan_ctrl: RTL and testbench

- Byte-command engine between cmd_parser (upstream) and the CSoC test pins (downstream).
- Turns opcode/data bytes into scan shifts, capture pulses and free-run bursts on csoc_clk, csoc_test_se, csoc_test_tm, csoc_rstn and csoc_data_o.
- Returns exactly one response byte per command on a valid/ready channel, which cmd_parser forwards to uart_tx.

---
 rtl/csoc_scan_pkg.sv | 23 ++
 rtl/csoc_clk_gen.sv | 58 +++++
 rtl/csoc_scan_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_csoc_scan_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csoc_scan_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the CSoC scan controller.
package csoc_scan_pkg;

  localparam logic [2:0] OP_SET_MODE   = 3'd0;
  localparam logic [2:0] OP_SHIFT      = 3'd1;
  localparam logic [2:0] OP_CAPTURE    = 3'd2;
  localparam logic [2:0] OP_SET_RUN_LO = 3'd3;
  localparam logic [2:0] OP_SET_RUN_HI = 3'd4;
  localparam logic [2:0] OP_RUN        = 3'd5;
  localparam logic [2:0] OP_READ       = 3'd6;

  localparam logic [7:0] RSP_ACK = 8'hA5;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_RESP
  } state_e;

endpackage

// File: rtl/csoc_clk_gen.sv
// Half-period counter producing the registered csoc_clk and one-cycle-early
// rise/fall strobes; a pulse train continues while cont is high at each fall.
module csoc_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic cont,
  output logic rise_strobe,
  output logic fall_strobe,
  output logic csoc_clk
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          clk_q, clk_d;
  logic          at_edge;

  always_comb begin
    at_edge     = active_q && (cnt_q == CNT_LAST);
    rise_strobe = at_edge && !clk_q;
    fall_strobe = at_edge && clk_q;
    cnt_d       = cnt_q;
    active_d    = active_q;
    clk_d       = clk_q;
    if (start) begin
      cnt_d    = '0;
      active_d = 1'b1;
      clk_d    = 1'b0;
    end else if (at_edge) begin
      cnt_d = '0;
      clk_d = !clk_q;
      // The train stops at a fall unless the owner asks for another pulse.
      if (fall_strobe) active_d = cont;
    end else if (active_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      clk_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      clk_q    <= clk_d;
    end
  end

  assign csoc_clk = clk_q;

endmodule

// File: rtl/csoc_scan_ctrl.sv
// Byte-command engine driving CSoC scan/test pins, one response per command.
// Define CSOC_SCAN_LOOPBACK_EN to sample the registered csoc_data_o instead of csoc_data_i.
module csoc_scan_ctrl
  import csoc_scan_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int RUN_W   = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       csoc_clk,
  output logic       csoc_rstn,
  output logic       csoc_test_se,
  output logic       csoc_test_tm,
  output logic [7:0] csoc_data_o,
  input  logic [7:0] csoc_data_i
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             tm_q, tm_d;
  logic             se_q, se_d;
  logic             mode_se_q, mode_se_d;
  logic             crstn_q, crstn_d;
  logic [7:0]       dout_q, dout_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [RUN_W-1:0] wcnt_q, wcnt_d;
  logic             clk_start, clk_cont, rise_strobe, fall_strobe;
  logic [7:0]       sample_src;

`ifdef CSOC_SCAN_LOOPBACK_EN
  assign sample_src = dout_q;
`else
  assign sample_src = csoc_data_i;
`endif

  // Byte-lane write into the run count; lanes beyond RUN_W simply vanish.
  function automatic logic [RUN_W-1:0] load_byte(input logic [RUN_W-1:0] cur,
                                                 input logic [7:0] b, input logic hi);
    logic [RUN_W-1:0] r;
    r = cur;
    for (int i = 0; i < RUN_W; i++) begin
      if ((hi && i >= 8 && i < 16) || (!hi && i < 8)) r[i] = b[i % 8];
    end
    return r;
  endfunction

  assign clk_cont = (op_q == OP_RUN) && (wcnt_q != RUN_W'(1));

  csoc_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk         (clk),
    .rstn        (rstn),
    .start       (clk_start),
    .cont        (clk_cont),
    .rise_strobe (rise_strobe),
    .fall_strobe (fall_strobe),
    .csoc_clk    (csoc_clk)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    tm_d       = tm_q;
    se_d       = se_q;
    mode_se_d  = mode_se_q;
    crstn_d    = crstn_q;
    dout_d     = dout_q;
    rsp_data_d = rsp_data_q;
    run_cnt_d  = run_cnt_q;
    wcnt_d     = wcnt_q;
    clk_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          state_d = ST_RESP;
          case (cmd_op)
            OP_SET_MODE: begin
              tm_d       = cmd_data[0];
              se_d       = cmd_data[1];
              mode_se_d  = cmd_data[1];
              crstn_d    = cmd_data[2];
              rsp_data_d = {5'b0, cmd_data[2:0]};
            end
            OP_SHIFT: begin
              dout_d    = cmd_data;
              se_d      = 1'b1;
              clk_start = 1'b1;
              state_d   = ST_SETUP;
            end
            OP_CAPTURE: begin
              se_d      = 1'b0;
              clk_start = 1'b1;
              state_d   = ST_SETUP;
            end
            OP_SET_RUN_LO: begin
              run_cnt_d  = load_byte(run_cnt_q, cmd_data, 1'b0);
              rsp_data_d = RSP_ACK;
            end
            OP_SET_RUN_HI: begin
              run_cnt_d  = load_byte(run_cnt_q, cmd_data, 1'b1);
              rsp_data_d = RSP_ACK;
            end
            OP_RUN: begin
              rsp_data_d = RSP_ACK;
              if (run_cnt_q != '0) begin
                wcnt_d    = run_cnt_q;
                clk_start = 1'b1;
                state_d   = ST_SETUP;
              end
            end
            OP_READ:  rsp_data_d = sample_src;
            default:  rsp_data_d = RSP_ERR;
          endcase
        end
      end
      ST_SETUP, ST_LOW: begin
        if (rise_strobe) begin
          state_d = ST_HIGH;
          if (op_q != OP_RUN) rsp_data_d = sample_src;
        end
      end
      ST_HIGH: begin
        if (fall_strobe) begin
          if (op_q == OP_RUN) begin
            wcnt_d = wcnt_q - 1'b1;
            if (wcnt_q == RUN_W'(1)) begin
              rsp_data_d = RSP_ACK;
              state_d    = ST_RESP;
            end else begin
              state_d = ST_LOW;
            end
          end else begin
            se_d    = mode_se_q;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      tm_q       <= 1'b0;
      se_q       <= 1'b0;
      mode_se_q  <= 1'b0;
      crstn_q    <= 1'b0;
      dout_q     <= '0;
      rsp_data_q <= '0;
      run_cnt_q  <= '0;
      wcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      tm_q       <= tm_d;
      se_q       <= se_d;
      mode_se_q  <= mode_se_d;
      crstn_q    <= crstn_d;
      dout_q     <= dout_d;
      rsp_data_q <= rsp_data_d;
      run_cnt_q  <= run_cnt_d;
      wcnt_q     <= wcnt_d;
    end
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_data     = rsp_data_q;
  assign csoc_rstn    = crstn_q;
  assign csoc_test_se = se_q;
  assign csoc_test_tm = tm_q;
  assign csoc_data_o  = dout_q;

endmodule

// File: tb/tb_csoc_scan_ctrl.sv
// Bench for csoc_scan_ctrl: directed vector table, hand-written corner sequences
// and randomized commands checked against a command-level reference model.
module tb_csoc_scan_ctrl;
  import csoc_scan_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int RUN_W   = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_data = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       busy;
  logic       csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm;
  logic [7:0] csoc_data_o;
  logic [7:0] csoc_data_i = '0;

  always #5 clk = ~clk;

  csoc_scan_ctrl #(.CLK_DIV(CLK_DIV), .RUN_W(RUN_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .csoc_clk     (csoc_clk),
    .csoc_rstn    (csoc_rstn),
    .csoc_test_se (csoc_test_se),
    .csoc_test_tm (csoc_test_tm),
    .csoc_data_o  (csoc_data_o),
    .csoc_data_i  (csoc_data_i)
  );

  int rise_cnt = 0;
  always @(posedge csoc_clk) rise_cnt++;

  int tests = 0;
  int fails = 0;

  // Reference model state: what the pins and run count should be between commands.
  logic        m_tm, m_se, m_rstn;
  logic [7:0]  m_dout;
  logic [15:0] m_count;

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic [7:0] di;
    logic [7:0] rsp;
    int         pulses;
    int         lat;
    logic [2:0] pins;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] src(input logic [7:0] di, input logic [7:0] dout);
`ifdef CSOC_SCAN_LOOPBACK_EN
    return dout;
`else
    return di;
`endif
  endfunction

  task automatic model_reset();
    m_tm = 1'b0; m_se = 1'b0; m_rstn = 1'b0; m_dout = '0; m_count = '0;
  endtask

  task automatic model_cmd(input logic [2:0] op, input logic [7:0] d, input logic [7:0] di,
                           output logic [7:0] rsp, output int pulses, output int lat);
    pulses = 0;
    lat    = 0;
    rsp    = RSP_ACK;
    case (op)
      3'd0: begin m_tm = d[0]; m_se = d[1]; m_rstn = d[2]; rsp = {5'b0, d[2:0]}; end
      3'd1: begin m_dout = d; rsp = src(di, m_dout); pulses = 1; lat = 2 * CLK_DIV; end
      3'd2: begin rsp = src(di, m_dout); pulses = 1; lat = 2 * CLK_DIV; end
      3'd3: m_count[7:0] = d;
      3'd4: m_count[15:8] = d;
      3'd5: begin pulses = int'(m_count); lat = 2 * CLK_DIV * int'(m_count); end
      3'd6: rsp = src(di, m_dout);
      default: rsp = RSP_ERR;
    endcase
  endtask

  task automatic rsp_handshake(input string name);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({name, "_hs"}, {cmd_ready, rsp_valid, busy}, 3'b100);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [7:0] d, input logic [7:0] di,
                         input logic [7:0] exp_rsp, input int exp_pulses, input int exp_lat,
                         input logic [2:0] exp_pins, input logic [7:0] exp_dout,
                         input string name);
    int n;
    int base;
    int lat;
    @(negedge clk);
    cmd_op = op; cmd_data = d; csoc_data_i = di; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk({name, "_ready_timeout"}, cmd_ready, 1);
    @(posedge clk);
    base = rise_cnt;
    #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < exp_lat + 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_rsp"}, rsp_data, exp_rsp);
    chk({name, "_pulses"}, rise_cnt - base, exp_pulses);
    chk({name, "_pins"}, {csoc_rstn, csoc_test_se, csoc_test_tm, csoc_data_o, csoc_clk},
        {exp_pins, exp_dout, 1'b0});
    rsp_handshake(name);
  endtask

  initial begin
    logic [8:0] clk_pat, vld_pat;
    logic [7:0] e_rsp;
    logic [2:0] op;
    logic [7:0] d, di;
    int pulses, lat, n, base, stable, seen;

    tbl[0]  = '{OP_SET_MODE,   8'h07, 8'h00, 8'h07,              0,   0,    3'b111, 8'h00};
    tbl[1]  = '{OP_SHIFT,      8'h3C, 8'h81, src(8'h81, 8'h3C),  1,   8,    3'b111, 8'h3C};
    tbl[2]  = '{OP_SET_RUN_LO, 8'h05, 8'h00, 8'hA5,              0,   0,    3'b111, 8'h3C};
    tbl[3]  = '{OP_SET_RUN_HI, 8'h00, 8'h00, 8'hA5,              0,   0,    3'b111, 8'h3C};
    tbl[4]  = '{OP_RUN,        8'h00, 8'h00, 8'hA5,              5,   40,   3'b111, 8'h3C};
    tbl[5]  = '{OP_RUN,        8'h00, 8'h00, 8'hA5,              5,   40,   3'b111, 8'h3C};
    tbl[6]  = '{OP_SET_MODE,   8'h05, 8'h00, 8'h05,              0,   0,    3'b101, 8'h3C};
    tbl[7]  = '{OP_CAPTURE,    8'h00, 8'hC3, src(8'hC3, 8'h3C),  1,   8,    3'b101, 8'h3C};
    tbl[8]  = '{OP_READ,       8'h00, 8'h5A, src(8'h5A, 8'h3C),  0,   0,    3'b101, 8'h3C};
    tbl[9]  = '{3'd7,          8'hFF, 8'h00, 8'hEE,              0,   0,    3'b101, 8'h3C};
    tbl[10] = '{OP_SET_RUN_LO, 8'h00, 8'h00, 8'hA5,              0,   0,    3'b101, 8'h3C};
    tbl[11] = '{OP_RUN,        8'h00, 8'h00, 8'hA5,              0,   0,    3'b101, 8'h3C};
    tbl[12] = '{OP_SET_RUN_HI, 8'h01, 8'h00, 8'hA5,              0,   0,    3'b101, 8'h3C};
    tbl[13] = '{OP_RUN,        8'h00, 8'h00, 8'hA5,              256, 2048, 3'b101, 8'h3C};
    tbl[14] = '{OP_SET_RUN_HI, 8'h00, 8'h00, 8'hA5,              0,   0,    3'b101, 8'h3C};

    // Reset values while rstn is held low
    #12;
    chk("reset_outputs",
        {csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm, csoc_data_o, rsp_valid, rsp_data, busy},
        '0);
    chk("reset_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_cmd(tbl[i].op, tbl[i].data, tbl[i].di, tbl[i].rsp, tbl[i].pulses, tbl[i].lat,
              tbl[i].pins, tbl[i].dout, $sformatf("tbl%0d", i));
    end

    // SHIFT waveform: data_i is only valid around the rising edge at T+CLK_DIV
    @(negedge clk);
    cmd_op = OP_SHIFT; cmd_data = 8'h3C; csoc_data_i = 8'h18; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("shift_at_T", {csoc_data_o, csoc_test_se, busy, cmd_ready}, {8'h3C, 1'b1, 1'b1, 1'b0});
    clk_pat = '0;
    vld_pat = '0;
    for (int k = 0; k <= 2 * CLK_DIV; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      clk_pat[k] = csoc_clk;
      vld_pat[k] = rsp_valid;
      if (k == CLK_DIV - 1) csoc_data_i = 8'h81;
      if (k == CLK_DIV)     csoc_data_i = 8'h00;
    end
    chk("shift_clk_wave", clk_pat, 9'b0_1111_0000);
    chk("shift_vld_wave", vld_pat, 9'b1_0000_0000);
    chk("shift_rsp", rsp_data, src(8'h81, 8'h3C));
    chk("shift_se_restored", csoc_test_se, 0);
    rsp_handshake("shift");

    // CAPTURE with a stalled consumer and a pending command
    run_cmd(OP_SET_MODE, 8'h07, 8'h00, 8'h07, 0, 0, 3'b111, 8'h3C, "stall_mode");
    @(negedge clk);
    cmd_op = OP_CAPTURE; cmd_data = 8'hFF; csoc_data_i = 8'h66; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("cap_se_forced", {csoc_test_se, csoc_data_o}, {1'b0, 8'h3C});
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("cap_latency", n, 2 * CLK_DIV);
    chk("cap_se_restored", csoc_test_se, 1);
    e_rsp = src(8'h66, 8'h3C);
    @(negedge clk);
    cmd_op = OP_SET_MODE; cmd_data = 8'h00; cmd_valid = 1'b1;
    stable = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid && rsp_data == e_rsp && csoc_test_tm && csoc_test_se && csoc_rstn &&
          !cmd_ready && busy) stable++;
    end
    chk("stall_stable_cycles", stable, 20);
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_handshake("stall");
    chk("stall_pins_kept", {csoc_rstn, csoc_test_se, csoc_test_tm}, 3'b111);

    // Asynchronous reset while the third RUN pulse is high
    run_cmd(OP_SET_RUN_LO, 8'h05, 8'h00, 8'hA5, 0, 0, 3'b111, 8'h3C, "rst_lo");
    @(negedge clk);
    cmd_op = OP_RUN; cmd_data = 8'h00; cmd_valid = 1'b1;
    @(posedge clk);
    base = rise_cnt;
    #1;
    cmd_valid = 1'b0;
    n = 0;
    while ((rise_cnt - base) < 3 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("run_third_pulse_high", {csoc_clk, busy}, 2'b11);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrun_reset",
        {csoc_clk, csoc_rstn, busy, rsp_valid, csoc_test_se, csoc_test_tm, csoc_data_o},
        '0);
    @(negedge clk);
    rstn = 1'b1;
    base = rise_cnt;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid || busy) seen++;
    end
    chk("no_rsp_after_reset", seen, 0);
    chk("no_pulse_after_reset", rise_cnt - base, 0);
    run_cmd(OP_RUN, 8'h00, 8'h00, 8'hA5, 0, 0, 3'b000, 8'h00, "run_after_reset");

    // Randomized commands against the reference model
    model_reset();
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      d  = 8'($urandom);
      di = 8'($urandom);
      if (op == OP_SET_RUN_HI) d = 8'h00;
      if (op == OP_SET_RUN_LO) d = 8'($urandom_range(0, 10));
      model_cmd(op, d, di, e_rsp, pulses, lat);
      run_cmd(op, d, di, e_rsp, pulses, lat, {m_rstn, m_se, m_tm}, m_dout,
              $sformatf("rand%0d_op%0d", i, op));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
